dms_cp_seq: RTL and testbench

Digital sequencer that drives the `up`/`down` inputs of the CDR charge pump `dms_cp`. It converts synchronized reference and feedback edge events into charge-pump pulses. Every pulse carries a minimum-width anti-dead-zone overlap, and over-long pulses are cut off as cycle slips. The block also reports a signed phase-error count per comparison, maintains a lock indicator, and provides calibration overrides that force the pump up, down or idle.

---
 rtl/dms_pkg.sv | 19 +
 rtl/dms_lock_det.sv | 55 +++++
 rtl/dms_cp_seq.sv | 155 +++++++++++++++
 tb/tb_dms_cp_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dms_pkg.sv
// Shared types for the charge-pump sequencer: FSM state and calibration mode.
// No logic; enum encodings are referenced by the sequencer and lock detector.
package dms_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2,
    OVL  = 2'd3
  } cp_state_e;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    FORCE_UP = 2'd1,
    FORCE_DN = 2'd2,
    HOLD     = 2'd3
  } cal_mode_e;

endpackage

// File: rtl/dms_lock_det.sv
// Lock detector: counts consecutive in-tolerance comparisons, lock at LOCK_CNT.
// Fed with next-cycle strobes so lock moves in the same cycle as err_valid/slip; no backpressure.
module dms_lock_det
  import dms_pkg::*;
#(
  parameter int ERR_W    = 5,
  parameter int LOCK_CNT = 8,
  parameter int LOCK_TOL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             err_valid_i,
  input  logic [ERR_W-1:0] phase_err_i,
  input  logic             slip_i,
  input  logic             clr_i,
  output logic             lock_o
);

  localparam int LW = $clog2(LOCK_CNT + 1);

  logic [LW-1:0]    lcnt_q, lcnt_d;
  logic             lock_q;
  logic [ERR_W-1:0] mag;
  logic             in_tol;

  // Two's-complement magnitude; the most negative code maps to a large value.
  assign mag    = phase_err_i[ERR_W-1] ? (~phase_err_i + ERR_W'(1)) : phase_err_i;
  assign in_tol = (mag <= ERR_W'(LOCK_TOL));

  always_comb begin
    lcnt_d = lcnt_q;
    if (clr_i || slip_i) begin
      lcnt_d = '0;
    end else if (err_valid_i) begin
      if (!in_tol) begin
        lcnt_d = '0;
      end else if (lcnt_q != LW'(LOCK_CNT)) begin
        lcnt_d = lcnt_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt_q <= '0;
      lock_q <= 1'b0;
    end else begin
      lcnt_q <= lcnt_d;
      lock_q <= (lcnt_d == LW'(LOCK_CNT));
    end
  end

  assign lock_o = lock_q;

endmodule

// File: rtl/dms_cp_seq.sv
// Charge-pump sequencer: ref/fb edges -> up/down pulses with PW_MIN overlap tail and PW_MAX slip cutoff.
// One-cycle latency on every output; no backpressure, edges during OVL or calibration are dropped.
module dms_cp_seq
  import dms_pkg::*;
#(
  parameter int PW_MIN   = 2,
  parameter int PW_MAX   = 15,
  parameter int ERR_W    = 5,
  parameter int LOCK_CNT = 8,
  parameter int LOCK_TOL = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    ref_edge,
  input  logic                    fb_edge,
  input  logic [1:0]              cal_mode,
  output logic                    up,
  output logic                    down,
  output logic signed [ERR_W-1:0] phase_err,
  output logic                    err_valid,
  output logic                    slip,
  output logic                    lock
);

  localparam int OW = $clog2(PW_MIN + 1);

  cp_state_e               state_q, state_d;
  logic [ERR_W-1:0]        cnt_q, cnt_d;
  logic [OW-1:0]           ocnt_q, ocnt_d;
  logic signed [ERR_W-1:0] pe_q, pe_d;
  logic                    up_q, up_d, down_q, down_d;
  logic                    ev_q, ev_d, slip_q, slip_d;
  logic                    clr_d;
  cal_mode_e               cal_e;

  assign cal_e = cal_mode_e'(cal_mode);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ocnt_d  = ocnt_q;
    pe_d    = pe_q;
    ev_d    = 1'b0;
    slip_d  = 1'b0;
    clr_d   = 1'b0;
    if (!en || cal_e != NORMAL) begin
      state_d = IDLE;
      cnt_d   = '0;
      ocnt_d  = '0;
      clr_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (ref_edge && fb_edge) begin
            state_d = OVL;
            ocnt_d  = OW'(1);
            pe_d    = '0;
            ev_d    = 1'b1;
          end else if (ref_edge) begin
            state_d = UP;
            cnt_d   = ERR_W'(1);
          end else if (fb_edge) begin
            state_d = DN;
            cnt_d   = ERR_W'(1);
          end
        end
        UP: begin
          if (fb_edge) begin
            state_d = OVL;
            ocnt_d  = OW'(1);
            pe_d    = $signed(cnt_q);
            ev_d    = 1'b1;
            cnt_d   = '0;
          end else if (cnt_q == ERR_W'(PW_MAX)) begin
            state_d = IDLE;
            slip_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ERR_W'(1);
          end
        end
        DN: begin
          if (ref_edge) begin
            state_d = OVL;
            ocnt_d  = OW'(1);
            pe_d    = -$signed(cnt_q);
            ev_d    = 1'b1;
            cnt_d   = '0;
          end else if (cnt_q == ERR_W'(PW_MAX)) begin
            state_d = IDLE;
            slip_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ERR_W'(1);
          end
        end
        OVL: begin
          if (ocnt_q == OW'(PW_MIN)) begin
            state_d = IDLE;
            ocnt_d  = '0;
          end else begin
            ocnt_d = ocnt_q + OW'(1);
          end
        end
      endcase
    end

    up_d   = (state_d == UP) || (state_d == OVL) || (en && cal_e == FORCE_UP);
    down_d = (state_d == DN) || (state_d == OVL) || (en && cal_e == FORCE_DN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ocnt_q  <= '0;
      pe_q    <= '0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      ev_q    <= 1'b0;
      slip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ocnt_q  <= ocnt_d;
      pe_q    <= pe_d;
      up_q    <= up_d;
      down_q  <= down_d;
      ev_q    <= ev_d;
      slip_q  <= slip_d;
    end
  end

  dms_lock_det #(
    .ERR_W   (ERR_W),
    .LOCK_CNT(LOCK_CNT),
    .LOCK_TOL(LOCK_TOL)
  ) u_lock_det (
    .clk        (clk),
    .rst        (rst),
    .err_valid_i(ev_d),
    .phase_err_i(pe_d),
    .slip_i     (slip_d),
    .clr_i      (clr_d),
    .lock_o     (lock)
  );

  assign up        = up_q;
  assign down      = down_q;
  assign phase_err = pe_q;
  assign err_valid = ev_q;
  assign slip      = slip_q;

endmodule

// File: tb/tb_dms_cp_seq.sv
// Bench for dms_cp_seq: timestamp-based reference model checked every cycle, plus directed literal checks.
module tb_dms_cp_seq;

  localparam int PW_MIN   = 2;
  localparam int PW_MAX   = 15;
  localparam int ERR_W    = 5;
  localparam int LOCK_CNT = 8;
  localparam int LOCK_TOL = 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    en = 1'b1;
  logic                    ref_edge = 1'b0;
  logic                    fb_edge = 1'b0;
  logic [1:0]              cal_mode = 2'd0;
  logic                    up, down, err_valid, slip, lock;
  logic signed [ERR_W-1:0] phase_err;

  dms_cp_seq #(
    .PW_MIN(PW_MIN), .PW_MAX(PW_MAX), .ERR_W(ERR_W),
    .LOCK_CNT(LOCK_CNT), .LOCK_TOL(LOCK_TOL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ref_edge(ref_edge), .fb_edge(fb_edge),
    .cal_mode(cal_mode), .up(up), .down(down), .phase_err(phase_err),
    .err_valid(err_valid), .slip(slip), .lock(lock)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a pulse is a direction plus its start cycle; overlap is an end cycle.
  int cyc = 0;
  int m_dir = 0;
  int m_t0 = 0;
  int m_ovl_end = -100;
  int m_lrun = 0;
  int e_pe = 0;
  bit e_up, e_dn, e_ev, e_slip, e_lock;

  int mon_up = 0, mon_dn = 0, mon_ov = 0, mon_ev = 0, mon_slip = 0;
  int mon_pe = 0, mon_ev_cyc = 0, mon_slip_cyc = 0, ref_cyc = 0;
  bit mon_lock_ev = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic finish_cmp(input int err);
    int mag;
    m_dir     = 0;
    m_ovl_end = cyc + PW_MIN;
    e_pe      = err;
    e_ev      = 1;
    mag       = (err < 0) ? -err : err;
    if (mag <= LOCK_TOL) begin
      m_lrun++;
      e_lock = (m_lrun >= LOCK_CNT);
    end else begin
      m_lrun = 0;
      e_lock = 0;
    end
  endtask

  task automatic model_step();
    int el;
    cyc++;
    e_ev   = 0;
    e_slip = 0;
    if (rst) begin
      m_dir = 0; m_ovl_end = -100; m_lrun = 0;
      e_pe = 0; e_up = 0; e_dn = 0; e_lock = 0;
    end else if (!en || cal_mode != 2'd0) begin
      m_dir = 0; m_ovl_end = -100; m_lrun = 0; e_lock = 0;
      e_up = en && (cal_mode == 2'd1);
      e_dn = en && (cal_mode == 2'd2);
    end else begin
      if (cyc <= m_ovl_end) begin
        // edges land inside the overlap tail and are discarded
      end else if (m_dir != 0) begin
        el = cyc - m_t0;
        if ((m_dir > 0 && fb_edge) || (m_dir < 0 && ref_edge)) begin
          finish_cmp(m_dir * el);
        end else if (el == PW_MAX) begin
          m_dir = 0; e_slip = 1; m_lrun = 0; e_lock = 0;
        end
      end else if (ref_edge && fb_edge) begin
        finish_cmp(0);
      end else if (ref_edge) begin
        m_dir = 1; m_t0 = cyc;
      end else if (fb_edge) begin
        m_dir = -1; m_t0 = cyc;
      end
      e_up = (m_dir > 0) || (cyc + 1 <= m_ovl_end);
      e_dn = (m_dir < 0) || (cyc + 1 <= m_ovl_end);
    end
  endtask

  task automatic tick(input bit r, input bit f);
    @(negedge clk);
    ref_edge = r;
    fb_edge  = f;
    @(posedge clk);
    model_step();
    if (r) ref_cyc = cyc;
    #1;
    chk("up", int'(up), int'(e_up));
    chk("down", int'(down), int'(e_dn));
    chk("err_valid", int'(err_valid), int'(e_ev));
    chk("slip", int'(slip), int'(e_slip));
    chk("lock", int'(lock), int'(e_lock));
    chk("phase_err", int'(phase_err), e_pe);
    if (up && !down) mon_up++;
    if (!up && down) mon_dn++;
    if (up && down) mon_ov++;
    if (err_valid) begin
      mon_ev++; mon_pe = int'(phase_err); mon_lock_ev = lock; mon_ev_cyc = cyc + 1;
    end
    if (slip) begin
      mon_slip++; mon_slip_cyc = cyc + 1;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick(0, 0);
  endtask

  task automatic do_err(input int e);
    if (e == 0) begin
      tick(1, 1);
    end else if (e > 0) begin
      tick(1, 0); idle(e - 1); tick(0, 1);
    end else begin
      tick(0, 1); idle(-e - 1); tick(1, 0);
    end
    idle(3);
  endtask

  int s_up, s_dn, s_ov, s_ev, s_slip;

  task automatic snap();
    s_up = mon_up; s_dn = mon_dn; s_ov = mon_ov; s_ev = mon_ev; s_slip = mon_slip;
  endtask

  initial begin
    tick(0, 0);
    tick(0, 0);
    rst = 1'b0;
    idle(2);
    chk("reset up", int'(up), 0);
    chk("reset lock", int'(lock), 0);
    chk("reset phase_err", int'(phase_err), 0);

    // ref leads fb by 4
    snap();
    tick(1, 0); idle(3); tick(0, 1); idle(4);
    chk("A phase_err", mon_pe, 4);
    chk("A up cycles", mon_up - s_up, 4);
    chk("A overlap cycles", mon_ov - s_ov, 2);
    chk("A err latency", mon_ev_cyc - ref_cyc, 5);

    // fb leads ref by 3
    snap();
    tick(0, 1); idle(2); tick(1, 0); idle(4);
    chk("B phase_err", mon_pe, -3);
    chk("B down cycles", mon_dn - s_dn, 3);

    // coincident edges; edges during the overlap are dropped
    snap();
    tick(1, 1); tick(1, 0); tick(0, 1); idle(3);
    chk("C phase_err", mon_pe, 0);
    chk("C overlap cycles", mon_ov - s_ov, 2);
    chk("C no pulse", (mon_up - s_up) + (mon_dn - s_dn), 0);
    chk("C one compare", mon_ev - s_ev, 1);

    // slip
    snap();
    tick(1, 0); idle(20);
    chk("slip up cycles", mon_up - s_up, 15);
    chk("slip count", mon_slip - s_slip, 1);
    chk("slip latency", mon_slip_cyc - ref_cyc, 16);
    chk("slip no err_valid", mon_ev - s_ev, 0);
    chk("slip lock", int'(lock), 0);

    // lock acquisition then loss
    for (int k = 0; k < 9; k++) begin
      do_err((k % 3 == 0) ? 1 : ((k % 3 == 1) ? 0 : -1));
      if (k == 6) chk("lock after 7", int'(mon_lock_ev), 0);
      if (k == 7) chk("lock after 8", int'(mon_lock_ev), 1);
      if (k == 8) chk("lock after 9", int'(mon_lock_ev), 1);
    end
    do_err(3);
    chk("lock err +3 pe", mon_pe, 3);
    chk("lock lost", int'(mon_lock_ev), 0);

    // calibration override mid-DN pulse
    snap();
    tick(0, 1); idle(2);
    cal_mode = 2'd1;
    tick(0, 0);
    chk("force_up up", int'(up), 1);
    chk("force_up down", int'(down), 0);
    tick(1, 0); tick(0, 1); tick(1, 1);
    chk("force_up edges ignored", mon_ev - s_ev, 0);
    chk("force_up held", int'(up), 1);
    cal_mode = 2'd2;
    tick(0, 0);
    chk("force_dn down", int'(down), 1);
    cal_mode = 2'd3;
    tick(1, 0);
    chk("hold up", int'(up), 0);
    cal_mode = 2'd0;
    tick(0, 0);
    chk("normal idle", int'(up) + int'(down), 0);
    do_err(1);
    chk("post-cal phase_err", mon_pe, 1);

    // enable low mid-pulse
    tick(1, 0); tick(0, 0);
    en = 1'b0;
    tick(0, 1);
    chk("en low up", int'(up), 0);
    chk("en low keeps phase_err", int'(phase_err), 1);
    en = 1'b1;
    idle(3);

    // build lock then reset during overlap
    for (int k = 0; k < 8; k++) do_err(0);
    chk("lock before rst", int'(lock), 1);
    tick(1, 1);
    rst = 1'b1;
    tick(0, 0);
    chk("rst up", int'(up), 0);
    chk("rst down", int'(down), 0);
    chk("rst lock", int'(lock), 0);
    rst = 1'b0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
